// File: rtl/spi_xfer_arbiter.sv
// Two-requester SPI mode-0 byte engine with round-robin arbitration, burst locking
// and per-byte slow/fast SCK selection.
module spi_xfer_arbiter #(
  parameter int DIV_SLOW = 64,
  parameter int DIV_FAST = 4,
  parameter int GAP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  input  logic [1:0]  req_fast,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [1:0]  spi_cs_n
);

  localparam int CW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] SLOW_RELOAD = CW'(DIV_SLOW - 1);
  localparam logic [CW-1:0] FAST_RELOAD = CW'(DIV_FAST - 1);
  localparam logic [GW-1:0] GAP_RELOAD  = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOCKED,
    ST_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rxreg_q, rxreg_d;
  logic            last_q, last_d;
  logic            fast_q, fast_d;
  logic            owner_q, owner_d;
  logic            prio_q, prio_d;
  logic [CW-1:0]   div_cnt_q, div_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]      cs_n_q, cs_n_d;
  logic            sck_q, sck_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;

  logic            winner;
  logic            acc_id;
  logic            accept;
  logic [7:0]      acc_byte;
  logic [CW-1:0]   div_reload;

  // On a tie the favoured requester wins; in LOCKED only the burst owner is eligible.
  always_comb begin
    winner    = (req_valid == 2'b11) ? prio_q : req_valid[1];
    acc_id    = (state_q == ST_LOCKED) ? owner_q : winner;
    req_ready = 2'b00;
    if (!rst) begin
      if (state_q == ST_IDLE && req_valid != 2'b00) begin
        req_ready[winner] = 1'b1;
      end else if (state_q == ST_LOCKED) begin
        req_ready[owner_q] = req_valid[owner_q];
      end
    end
    accept     = (req_valid & req_ready) != 2'b00;
    acc_byte   = acc_id ? req_data[15:8] : req_data[7:0];
    div_reload = fast_q ? FAST_RELOAD : SLOW_RELOAD;
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rxreg_d     = rxreg_q;
    last_d      = last_q;
    fast_d      = fast_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      ST_IDLE, ST_LOCKED: begin
        if (accept) begin
          owner_d   = acc_id;
          shreg_d   = acc_byte;
          last_d    = req_last[acc_id];
          fast_d    = req_fast[acc_id];
          div_cnt_d = req_fast[acc_id] ? FAST_RELOAD : SLOW_RELOAD;
          bit_cnt_d = 3'd0;
          cs_n_d    = acc_id ? 2'b01 : 2'b10;
          sck_d     = 1'b0;
          state_d   = ST_SHIFT_LO;
        end
      end

      ST_SHIFT_LO: begin
        if (div_cnt_q == '0) begin
          rxreg_d   = {rxreg_q[6:0], spi_miso};
          sck_d     = 1'b1;
          div_cnt_d = div_reload;
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      ST_SHIFT_HI: begin
        if (div_cnt_q == '0) begin
          sck_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = owner_q;
            rsp_data_d  = rxreg_q;
            if (last_q) begin
              cs_n_d    = 2'b11;
              prio_d    = ~owner_q;
              gap_cnt_d = GAP_RELOAD;
              state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
            end else begin
              state_d = ST_LOCKED;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {shreg_q[6:0], 1'b0};
            div_cnt_d = div_reload;
            state_d   = ST_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= 8'h00;
      rxreg_q     <= 8'h00;
      last_q      <= 1'b0;
      fast_q      <= 1'b0;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= 3'd0;
      gap_cnt_q   <= '0;
      cs_n_q      <= 2'b11;
      sck_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rxreg_q     <= rxreg_d;
      last_q      <= last_d;
      fast_q      <= fast_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // MOSI is the top of the shift register, so it is already bit 7 right after accept.
  assign spi_mosi  = shreg_q[7];
  assign spi_clk   = sck_q;
  assign spi_cs_n  = cs_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: a time-window reference model checked every cycle
// plus literal latency/data/order expectations per scenario.
module tb_spi_xfer_arbiter;

  localparam int DS = 64;
  localparam int DF = 4;
  localparam int GP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic l0 = 1'b0, l1 = 1'b0, f0 = 1'b0, f1 = 1'b0;
  logic miso_const = 1'b0;

  logic [1:0]  req_valid, req_ready, req_last, req_fast, spi_cs_n;
  logic [15:0] req_data;
  logic        rsp_valid, rsp_id, spi_clk, spi_mosi, spi_miso;
  logic [7:0]  rsp_data;

  assign req_valid = {v1, v0};
  assign req_data  = {d1, d0};
  assign req_last  = {l1, l0};
  assign req_fast  = {f1, f0};
  assign spi_miso  = miso_const ? 1'b1 : spi_mosi;

  spi_xfer_arbiter #(.DIV_SLOW(DS), .DIV_FAST(DF), .GAP(GP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_last(req_last), .req_fast(req_fast),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sck_rises = 0;
  int order_q[$];

  // Model: e counts clock edges since reset; the byte accepted at edge a_edge fills
  // cycles a_edge+1 .. a_edge+16*div, completes in the next cycle, then either locks
  // the bus for its owner or leaves a GP-cycle gap before arbitration reopens.
  int         e = 0;
  int         a_edge = -1;
  int         m_div = DS;
  logic       m_owner = 1'b0, m_last = 1'b0, prio = 1'b0;
  logic [7:0] m_tx = 8'h00, m_rx = 8'h00;
  logic       exp_rsp_id = 1'b0;
  logic [7:0] exp_rsp_data = 8'h00;
  logic [1:0] exp_ready = 2'b00;
  bit         chk_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge spi_clk) sck_rises++;

  always @(posedge clk) begin
    if (rst) begin
      e = 0; a_edge = -1; prio = 1'b0;
      exp_rsp_id = 1'b0; exp_rsp_data = 8'h00;
    end else begin
      e = e + 1;
      if ((exp_ready & req_valid) != 2'b00) begin
        m_owner = exp_ready[1];
        a_edge  = e;
        m_tx    = m_owner ? d1 : d0;
        m_last  = m_owner ? l1 : l0;
        m_div   = (m_owner ? f1 : f0) ? DF : DS;
        m_rx    = miso_const ? 8'hFF : m_tx;
        if (m_last) prio = ~m_owner;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int c, k, h;
    logic [1:0] exp_cs;
    logic exp_clk, exp_rv, exp_mosi, in_byte, open;
    exp_ready = 2'b00;
    if (!rst) begin
      c = e + 1;
      exp_cs = 2'b11; exp_clk = 1'b0; exp_rv = 1'b0; exp_mosi = 1'b0;
      in_byte = 1'b0; open = (a_edge < 0);
      if (a_edge >= 0) begin
        k = c - a_edge;
        if (k >= 1 && k <= 16 * m_div) begin
          in_byte = 1'b1;
          h = (k - 1) / m_div;
          exp_cs[m_owner] = 1'b0;
          exp_clk  = h[0];
          exp_mosi = m_tx[7 - h / 2];
        end else begin
          if (k == 16 * m_div + 1) begin
            exp_rv = 1'b1; exp_rsp_id = m_owner; exp_rsp_data = m_rx;
          end
          if (!m_last) begin
            exp_cs[m_owner] = 1'b0;
            exp_ready[m_owner] = req_valid[m_owner];
          end else if (k >= 16 * m_div + GP + 1) begin
            open = 1'b1;
          end
        end
      end
      if (open) begin
        if (req_valid == 2'b11) exp_ready[prio] = 1'b1;
        else exp_ready = req_valid;
      end
      if (chk_en) begin
        check_output("cs_n", spi_cs_n, exp_cs);
        check_output("spi_clk", spi_clk, exp_clk);
        check_output("rsp_valid", rsp_valid, exp_rv);
        check_output("rsp_id", rsp_id, exp_rsp_id);
        check_output("rsp_data", rsp_data, exp_rsp_data);
        check_output("req_ready", req_ready, exp_ready);
        if (in_byte) check_output("mosi", spi_mosi, exp_mosi);
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l, input logic f);
    if (id == 0) begin v0 = v; d0 = d; l0 = l; f0 = f; end
    else begin v1 = v; d1 = d; l1 = l; f1 = f; end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset cs_n", spi_cs_n, 2'b11);
    check_output("reset spi_clk", spi_clk, 1'b0);
    check_output("reset mosi", spi_mosi, 1'b0);
    check_output("reset rsp_valid", rsp_valid, 1'b0);
    check_output("reset rsp_id", rsp_id, 1'b0);
    check_output("reset rsp_data", rsp_data, 8'h00);
    check_output("reset req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  // Presents one byte and returns the edge number at which it was accepted.
  task automatic send_byte(input int id, input logic [7:0] d, input logic l, input logic f,
                           output int acc_e);
    bit done = 1'b0;
    acc_e = -1;
    set_req(id, 1'b1, d, l, f);
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        @(posedge clk); #1;
        acc_e = e;
        done = 1'b1;
        order_q.push_back(id);
      end
    end
    set_req(id, 1'b0, 8'h00, 1'b0, 1'b0);
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: requester %0d never accepted", id);
    end
  endtask

  task automatic wait_rsp(output int rc, output logic [7:0] rd, output logic rid);
    bit got = 1'b0;
    rc = -1; rd = 8'h00; rid = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; rc = e + 1; rd = rsp_data; rid = rsp_id;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_timeout: no rsp_valid seen");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int a, a0, a1, a2, b1, b2, b3, c1, rc, s;
    logic [7:0] rd;
    logic rid;

    do_reset();

    $display("[TB] slow single byte");
    miso_const = 1'b0;
    s = sck_rises;
    send_byte(0, 8'hA5, 1'b1, 1'b0, a);
    wait_rsp(rc, rd, rid);
    check_output("slow latency", rc - a, 1025);
    check_output("slow data", rd, 8'hA5);
    check_output("slow id", rid, 1'b0);
    check_output("slow sck pulses", sck_rises - s, 8);
    repeat (10) @(posedge clk); #1;

    $display("[TB] fast byte, miso high");
    miso_const = 1'b1;
    send_byte(1, 8'h3C, 1'b1, 1'b1, a);
    wait_rsp(rc, rd, rid);
    check_output("fast latency", rc - a, 65);
    check_output("fast data", rd, 8'hFF);
    check_output("fast id", rid, 1'b1);
    repeat (10) @(posedge clk); #1;
    miso_const = 1'b0;

    $display("[TB] contention");
    do_reset();
    order_q.delete();
    fork
      send_byte(0, 8'h11, 1'b1, 1'b1, a0);
      send_byte(1, 8'h22, 1'b1, 1'b1, a1);
    join
    check_output("gap to second grant", a1 - a0, 69);
    fork
      send_byte(0, 8'h33, 1'b1, 1'b1, a0);
      send_byte(1, 8'h44, 1'b1, 1'b1, a1);
    join
    check_output("order 0", order_q.size() > 0 ? order_q[0] : -1, 0);
    check_output("order 1", order_q.size() > 1 ? order_q[1] : -1, 1);
    check_output("order 2", order_q.size() > 2 ? order_q[2] : -1, 0);
    check_output("order 3", order_q.size() > 3 ? order_q[3] : -1, 1);
    repeat (100) @(posedge clk); #1;

    $display("[TB] burst lock");
    fork
      begin
        send_byte(0, 8'h01, 1'b0, 1'b1, b1);
        send_byte(0, 8'h02, 1'b0, 1'b1, b2);
        send_byte(0, 8'h03, 1'b1, 1'b1, b3);
      end
      send_byte(1, 8'h99, 1'b1, 1'b1, c1);
    join
    check_output("burst byte2 accept", b2 - b1, 65);
    check_output("burst byte3 accept", b3 - b2, 65);
    check_output("req1 after burst", c1 - b3, 69);
    repeat (100) @(posedge clk); #1;

    $display("[TB] reset mid-byte");
    send_byte(0, 8'hC3, 1'b1, 1'b0, a);
    repeat (7 * DS + 30) @(negedge clk);
    check_output("in 4th high phase", spi_clk, 1'b1);
    check_output("selected before reset", spi_cs_n, 2'b10);
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check_output("async cs_n", spi_cs_n, 2'b11);
    check_output("async spi_clk", spi_clk, 1'b0);
    check_output("async rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    send_byte(0, 8'h5A, 1'b1, 1'b0, a);
    wait_rsp(rc, rd, rid);
    check_output("post-reset latency", rc - a, 1025);
    check_output("post-reset data", rd, 8'h5A);
    check_output("post-reset id", rid, 1'b0);
    repeat (10) @(posedge clk); #1;

    $display("[TB] rate switch in burst");
    send_byte(1, 8'hB4, 1'b0, 1'b0, a1);
    send_byte(1, 8'h4B, 1'b1, 1'b1, a2);
    check_output("slow byte span", a2 - a1, 1025);
    wait_rsp(rc, rd, rid);
    check_output("fast byte latency", rc - a2, 65);
    check_output("fast byte data", rd, 8'h4B);
    check_output("fast byte id", rid, 1'b1);
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
